// File: rtl/conv_multi_kernel.sv
// conv_multi_kernel: N parallel KxK signed fixed-point kernels over one window, stallable 3-stage pipeline
module conv_multi_kernel #(
  parameter int NBIT = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int FRAC_BITS = 4,
  parameter int NUM_KERNELS = 2,
  localparam int K = KERNEL_SIZE,
  localparam int N = NUM_KERNELS,
  localparam int KK = K * K,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1,
  localparam int ADDR_W = $clog2(KK)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [K-1:0][K-1:0][NBIT-1:0] i_data,
  input  logic                         i_data_valid,
  input  logic                         i_stall,
  input  logic                         i_kwr_valid,
  input  logic [SEL_W-1:0]             i_kwr_sel,
  input  logic [ADDR_W-1:0]            i_kwr_addr,
  input  logic [NBIT-1:0]              i_kwr_data,
  input  logic                         i_kernel_commit,
  input  logic                         i_abs_mode,
  output logic [N-1:0][NBIT-1:0]       o_pixel,
  output logic                         o_valid,
  output logic                         o_kwr_err
);
  localparam int PW = 2 * NBIT + 1;
  localparam int ACC_W = PW + $clog2(KK);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'((2 ** FRAC_BITS) / 2);
  localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((2 ** NBIT) - 1);

  logic signed [NBIT-1:0]  r_shadow [N][KK];
  logic signed [NBIT-1:0]  r_active [N][KK];
  logic signed [PW-1:0]    r_prod [N][KK];
  logic signed [ACC_W-1:0] r_sum [N];
  logic [N-1:0][NBIT-1:0]  r_pix3;
  logic                    r_v1, r_v2, r_v3;
  logic                    w_kwr_ok;
  logic signed [ACC_W-1:0] w_sum [N];
  logic signed [ACC_W-1:0] w_rnd [N];
  logic signed [ACC_W-1:0] w_mag [N];
  logic [N-1:0][NBIT-1:0]  w_pix;

  assign w_kwr_ok = (32'(i_kwr_sel) < N) && (32'(i_kwr_addr) < KK);

  // serial coefficient load into the shadow bank; out-of-range writes are dropped and flagged
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      for (int n = 0; n < N; n++)
        for (int i = 0; i < KK; i++)
          r_shadow[n][i] <= '0;
      o_kwr_err <= 1'b0;
    end else begin
      if (i_kwr_valid && w_kwr_ok) r_shadow[i_kwr_sel][i_kwr_addr] <= i_kwr_data;
      o_kwr_err <= i_kwr_valid && !w_kwr_ok;
    end

  // atomic commit of the whole shadow bank, using its contents before this edge
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      for (int n = 0; n < N; n++)
        for (int i = 0; i < KK; i++)
          r_active[n][i] <= '0;
    end else if (i_kernel_commit) begin
      r_active <= r_shadow;
    end

  // S1: products bind the window to the active bank seen on the same edge
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_v1 <= 1'b0;
      for (int n = 0; n < N; n++)
        for (int i = 0; i < KK; i++)
          r_prod[n][i] <= '0;
    end else if (!i_stall) begin
      r_v1 <= i_data_valid;
      for (int n = 0; n < N; n++)
        for (int i = 0; i < KK; i++)
          r_prod[n][i] <= PW'($signed({1'b0, i_data[i/K][i%K]})) * PW'(r_active[n][i]);
    end

  // per-kernel adder tree over the registered products
  always_comb begin
    w_sum = '{default: '0};
    for (int n = 0; n < N; n++)
      for (int i = 0; i < KK; i++)
        w_sum[n] = w_sum[n] + ACC_W'(r_prod[n][i]);
  end

  // round half toward +inf, then abs or clamp-to-zero, then saturate to the pixel range
  always_comb begin
    w_rnd = '{default: '0};
    w_mag = '{default: '0};
    w_pix = '0;
    for (int n = 0; n < N; n++) begin
      w_rnd[n] = (r_sum[n] + RND) >>> FRAC_BITS;
      w_mag[n] = w_rnd[n][ACC_W-1] ? (i_abs_mode ? -w_rnd[n] : '0) : w_rnd[n];
      w_pix[n] = (w_mag[n] > PMAX) ? {NBIT{1'b1}} : w_mag[n][NBIT-1:0];
    end
  end

  // S2, S3 and output register; everything freezes on stall and o_pixel holds across bubbles
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      o_valid <= 1'b0;
      r_sum   <= '{default: '0};
      r_pix3  <= '0;
      o_pixel <= '0;
    end else if (!i_stall) begin
      r_v2    <= r_v1;
      r_sum   <= w_sum;
      r_v3    <= r_v2;
      r_pix3  <= w_pix;
      o_valid <= r_v3;
      if (r_v3) o_pixel <= r_pix3;
    end
endmodule

// File: tb/tb_conv_multi_kernel.sv
// tb_conv_multi_kernel: scoreboard bench for conv_multi_kernel
module tb_conv_multi_kernel;
  localparam int NBIT = 8, K = 3, F = 4, N = 2, KK = 9;
  typedef logic [K-1:0][K-1:0][NBIT-1:0] win_t;
  typedef logic [N-1:0][NBIT-1:0] pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  win_t data = '0;
  logic data_valid = 1'b0, stall = 1'b0, kwr_valid = 1'b0, commit = 1'b0, abs_mode = 1'b1;
  logic [0:0] kwr_sel = '0;
  logic [3:0] kwr_addr = '0;
  logic [NBIT-1:0] kwr_data = '0;
  pix_t pixel;
  logic valid, kwr_err;

  int n_chk = 0, n_err = 0;
  pix_t exp_q[$];
  pix_t cur_exp = '0;
  pix_t last_pix = '0;
  logic last_valid = 1'b0;
  logic exp_err = 1'b0;
  int sh[N][KK];
  int ac[N][KK];

  always #5 clk = ~clk;

  conv_multi_kernel #(.NBIT(NBIT), .KERNEL_SIZE(K), .FRAC_BITS(F), .NUM_KERNELS(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_valid(data_valid), .i_stall(stall),
    .i_kwr_valid(kwr_valid), .i_kwr_sel(kwr_sel), .i_kwr_addr(kwr_addr), .i_kwr_data(kwr_data),
    .i_kernel_commit(commit), .i_abs_mode(abs_mode), .o_pixel(pixel), .o_valid(valid),
    .o_kwr_err(kwr_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic pix_t model(input win_t w, input logic am);
    pix_t res;
    int s;
    res = '0;
    for (int n = 0; n < N; n++) begin
      s = 0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          s += int'(w[r][c]) * ac[n][r*K+c];
      s = (s + (1 << (F - 1))) >>> F;
      if (s < 0) s = am ? -s : 0;
      if (s > 255) s = 255;
      res[n] = s[7:0];
    end
    return res;
  endfunction

  function automatic win_t mkwin(input int l, input int m, input int r);
    win_t w;
    for (int i = 0; i < K; i++) begin
      w[i][0] = NBIT'(l);
      w[i][1] = NBIT'(m);
      w[i][2] = NBIT'(r);
    end
    return w;
  endfunction

  function automatic int sobel(input bit y, input int i);
    int a, b;
    a = y ? i / 3 : i % 3;
    b = y ? i % 3 : i / 3;
    return 16 * (a - 1) * ((b == 1) ? 2 : 1);
  endfunction

  task automatic tick();
    logic adv;
    adv = !stall && !rst;
    @(posedge clk);
    exp_err = 1'b0;
    if (!rst) begin
      if (data_valid && adv) exp_q.push_back(cur_exp);
      if (commit) ac = sh;
      if (kwr_valid) begin
        exp_err = !(int'(kwr_sel) < N && int'(kwr_addr) < KK);
        if (!exp_err) sh[kwr_sel][kwr_addr] = $signed(kwr_data);
      end
    end
    #1;
    check("kwr_err", kwr_err, exp_err);
    if (!adv || !valid) check("hold_pix", pixel, last_pix);
    if (!adv) check("hold_valid", valid, last_valid);
    if (adv && valid) begin
      if (exp_q.size() == 0) check("extra_valid", valid, 1'b0);
      else check("pixel", pixel, exp_q.pop_front());
    end
    last_pix = pixel;
    last_valid = valid;
  endtask

  task automatic wr(input int sel, input int addr, input int val);
    kwr_sel = 1'(sel);
    kwr_addr = 4'(addr);
    kwr_data = NBIT'(val);
    kwr_valid = 1'b1;
    tick();
    kwr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic win(input win_t w, input pix_t e);
    data = w;
    cur_exp = e;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (5) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    for (int n = 0; n < N; n++)
      for (int i = 0; i < KK; i++) begin
        sh[n][i] = 0;
        ac[n][i] = 0;
      end
    #3;
    check("rst_pix", pixel, 0);
    check("rst_valid", valid, 0);
    check("rst_err", kwr_err, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < KK; i++) begin
      wr(0, i, sobel(0, i));
      wr(1, i, sobel(1, i));
    end
    do_commit();
    abs_mode = 1'b1;
    win(mkwin(10, 30, 50), {8'd0, 8'd160});
    win(mkwin(50, 30, 10), {8'd0, 8'd160});
    win(mkwin(0, 128, 255), {8'd0, 8'd255});
    drain();
    abs_mode = 1'b0;
    win(mkwin(50, 30, 10), {8'd0, 8'd0});
    win(mkwin(10, 30, 50), {8'd0, 8'd160});
    drain();

    abs_mode = 1'b1;
    for (int i = 0; i < KK; i++) begin
      wr(0, i, 1);
      wr(1, i, -1);
    end
    do_commit();
    win(mkwin(9, 9, 9), {8'd5, 8'd5});
    win(mkwin(8, 8, 8), {8'd4, 8'd5});
    drain();

    for (int i = 0; i < KK; i++) wr(0, i, sobel(0, i));
    for (int i = 0; i < 20; i++) begin
      data = win_t'({$urandom, $urandom, $urandom});
      data_valid = (i != 5);
      stall = (i >= 8 && i < 12);
      commit = (i == 3 || i == 14);
      kwr_valid = (i == 3 || i == 10);
      kwr_sel = (i == 3) ? 1'b1 : 1'b0;
      kwr_addr = (i == 3) ? 4'd4 : 4'd9;
      kwr_data = (i == 3) ? 8'h10 : 8'h55;
      cur_exp = model(data, abs_mode);
      tick();
    end
    data_valid = 1'b0;
    stall = 1'b0;
    commit = 1'b0;
    kwr_valid = 1'b0;
    drain();
    check("k1_center", ac[1][4], 16);

    win(mkwin(10, 30, 50), model(mkwin(10, 30, 50), abs_mode));
    win(mkwin(40, 90, 20), model(mkwin(40, 90, 20), abs_mode));
    rst = 1'b1;
    #1;
    check("mid_rst_pix", pixel, 0);
    check("mid_rst_valid", valid, 0);
    exp_q.delete();
    for (int n = 0; n < N; n++)
      for (int i = 0; i < KK; i++) begin
        sh[n][i] = 0;
        ac[n][i] = 0;
      end
    last_pix = '0;
    last_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    win(mkwin(200, 200, 200), {8'd0, 8'd0});
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
